snake_game_ctrl: RTL and testbench
==================================

# snake_game_ctrl

Game sequencer for the snake datapath. Divides the system clock into movement ticks and pulses the datapath's step enable. Filters player direction input so the snake cannot reverse onto itself, and evaluates food, growth and collisions after each move. Sits between the button debouncer, the food generator and the movement datapath; drives the length and direction the datapath consumes.

## Interface
- MAX_LEN, 16, body segment slots in position vector
- NUM_LEN, 10, bits per cell index
- MAX_LEN_BIT_LEN, 4, width of len output
- INIT_LEN, 3, length after start
- TICK_DIV, 25_000_000, clk cycles per move
- TICK_W, 25, tick counter width
- SPEED_STEP, 1_000_000, period reduction per point (speedup build only)
- MIN_DIV, 5_000_000, period floor (speedup build only)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; starts game from IDLE or OVER
- btn_valid  in  1  one-cycle pulse, btn_dir valid
- btn_dir  in  2  requested direction (00 left, 01 right, 10 up, 11 down)
- body_pos  in  MAX_LEN*NUM_LEN  datapath position vector, head in [NUM_LEN-1:0]
- should_stop  in  1  datapath wall-hit flag
- food_valid  in  1  one-cycle pulse, food_pos valid
- food_pos  in  NUM_LEN  new food cell
- step  out  1  one-cycle datapath enable
- di  out  2  committed direction
- len  out  MAX_LEN_BIT_LEN  current snake length
- food_req  out  1  one-cycle request for new food
- score  out  8  food eaten, saturating
- game_over  out  1  high in OVER

## Operation
- States: IDLE, FOOD, RUN, SETTLE, EVAL, OVER.
- IDLE: start -> food_req pulse, len=INIT_LEN, score=0, di=01, go FOOD.
- FOOD: tick counter held. On food_valid, latch food_pos, go RUN.
- RUN: counter increments. At period-1 it clears, step pulses, di<=pending, go SETTLE.
- SETTLE: wait 2 cycles, then EVAL.
- EVAL, single cycle, priority order:
  - should_stop=1, or head equals any body segment k, 1<=k<=len-1 -> OVER.
  - head == latched food -> len+1 (saturate MAX_LEN-1), score+1 (saturate 255), food_req pulse, go FOOD.
  - otherwise -> RUN.
- OVER: game_over=1, step never pulses. start -> same actions as in IDLE.
- Direction filter:
  - btn_valid accepted in any state except OVER.
  - Rejected if btn_dir is the opposite of committed di (same bit1, different bit0).
  - Accepted value overwrites pending; latest wins.
  - Pending resets to 01 with di.
- start outside IDLE/OVER is ignored.

## Timing
- Reset values: step=0, di=01, len=INIT_LEN, food_req=0, score=0, game_over=0, state IDLE, counter 0, pending=01, latched food=0.
- All outputs are registered.
- di changes on the same edge at which step rises, so it is stable throughout the step cycle.
- btn_valid in the step cycle is checked against the new di and applies at the next step.
- Move period: exactly the tick period in RUN cycles, plus 2 SETTLE cycles, 1 EVAL cycle and any FOOD wait.
- food_valid outside FOOD is ignored.
- food_valid in the same cycle as food_req is not possible; the generator responds at least 1 cycle later.
- rst_n low at any time returns immediately to reset values, including mid-SETTLE and mid-FOOD.

## Configuration
- SNAKE_SPEEDUP_EN defined: period = max(TICK_DIV − score*SPEED_STEP, MIN_DIV), recomputed on entry to RUN.
- Speedup arithmetic is done at TICK_W+8 bits to avoid underflow.
- Undefined: period fixed at TICK_DIV; SPEED_STEP and MIN_DIV unused.

## Structure
- Package snake_pkg:
  - state enum
  - direction localparams DIR_LEFT/RIGHT/UP/DOWN
  - function is_opposite(a,b)
  - period computation function
- Sub-module snake_tick_gen:
  - counter with enable, clear and period input
  - outputs the wrap pulse

## Test plan
- Reset, start, food_valid with food_pos=100 (TICK_DIV=8): first step 8 cycles after FOOD exit; di=01; len=3.
- di=01, btn_dir=00 -> di stays 01. Then btn_dir=10 followed by btn_dir=11 before the next step -> di=11 at that step.
- Head reaches the food cell -> food_req one cycle after EVAL; len 3->4, score 1; no step until food_valid.
- Assert should_stop in EVAL -> game_over=1 and no further step. start -> len=3, score=0, food_req pulse.
- len=5 with head equal to body segment 3 -> OVER. Head equal to segment 5 (beyond len) -> stays in RUN.
- With SNAKE_SPEEDUP_EN, TICK_DIV=20, SPEED_STEP=4, MIN_DIV=8: score 0/1/3/5 gives periods 20/16/8/8. Separately, rst_n low during SETTLE restores all reset values immediately.

Source files
------------

// File: rtl/snake_pkg.sv
// ============================================================================
// Module : snake_pkg
// Brief  : Shared types, direction codes and helper functions for the snake
//          game sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package snake_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FOOD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_SETTLE = 3'd3,
        ST_EVAL   = 3'd4,
        ST_OVER   = 3'd5
    } state_t;

    localparam logic [1:0] DIR_LEFT  = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_UP    = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    // Opposite directions share the axis bit and differ in the sense bit.
    function automatic logic is_opposite(input logic [1:0] a, input logic [1:0] b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

    // max(tick_div - score*speed_step, min_div); compare before subtracting
    // so the difference never wraps.
    function automatic longint unsigned calc_period(
        input logic [7:0]      score,
        input longint unsigned tick_div,
        input longint unsigned speed_step,
        input longint unsigned min_div
    );
        longint unsigned w_red;
        w_red = 64'(score) * speed_step;
        if (w_red + min_div >= tick_div) begin
            return min_div;
        end
        return tick_div - w_red;
    endfunction

endpackage

`default_nettype wire

// File: rtl/snake_game_ctrl_if.sv
// ============================================================================
// Module : snake_game_ctrl_if
// Brief  : Signal bundle between the snake sequencer and its neighbours
//          (debouncer, food generator, movement datapath).
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface snake_game_ctrl_if #(
    parameter int MAX_LEN         = 16,
    parameter int NUM_LEN         = 10,
    parameter int MAX_LEN_BIT_LEN = 4
);
    logic                         start;
    logic                         btn_valid;
    logic [1:0]                   btn_dir;
    logic [MAX_LEN*NUM_LEN-1:0]   body_pos;
    logic                         should_stop;
    logic                         food_valid;
    logic [NUM_LEN-1:0]           food_pos;
    logic                         step;
    logic [1:0]                   di;
    logic [MAX_LEN_BIT_LEN-1:0]   len;
    logic                         food_req;
    logic [7:0]                   score;
    logic                         game_over;

    modport master (
        output start, btn_valid, btn_dir, body_pos, should_stop, food_valid, food_pos,
        input  step, di, len, food_req, score, game_over
    );

    modport slave (
        input  start, btn_valid, btn_dir, body_pos, should_stop, food_valid, food_pos,
        output step, di, len, food_req, score, game_over
    );
endinterface

`default_nettype wire

// File: rtl/snake_tick_gen.sv
// ============================================================================
// Module : snake_tick_gen
// Brief  : Movement tick counter with enable, clear and runtime period;
//          flags the last count of each period.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module snake_tick_gen #(
    parameter int TICK_W = 25
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_en,
    input  wire logic              i_clr,
    input  wire logic [TICK_W-1:0] i_period,
    output logic                   o_wrap
);
    logic [TICK_W-1:0] r_cnt;

    assign o_wrap = i_en && (r_cnt == i_period - TICK_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || o_wrap) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + TICK_W'(1);
        end
    end
endmodule

`default_nettype wire

// File: rtl/snake_game_ctrl.sv
// ============================================================================
// Module : snake_game_ctrl
// Brief  : Snake game sequencer: move ticks, direction filtering, food,
//          growth and collision evaluation. Define SNAKE_SPEEDUP_EN to shrink
//          the move period as the score rises.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int MAX_LEN         = 16,
    parameter int NUM_LEN         = 10,
    parameter int MAX_LEN_BIT_LEN = 4,
    parameter int INIT_LEN        = 3,
    parameter int TICK_DIV        = 25_000_000,
    parameter int TICK_W          = 25,
    parameter int SPEED_STEP      = 1_000_000,
    parameter int MIN_DIV         = 5_000_000
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    snake_game_ctrl_if.slave  ctrl_if
);
    localparam logic [MAX_LEN_BIT_LEN-1:0] c_INIT_LEN = MAX_LEN_BIT_LEN'(INIT_LEN);
    localparam logic [MAX_LEN_BIT_LEN-1:0] c_LEN_MAX  = MAX_LEN_BIT_LEN'(MAX_LEN - 1);

    state_t                     r_state;
    logic                       r_step;
    logic [1:0]                 r_di;
    logic [1:0]                 r_pend;
    logic [MAX_LEN_BIT_LEN-1:0] r_len;
    logic                       r_food_req;
    logic [7:0]                 r_score;
    logic                       r_game_over;
    logic [NUM_LEN-1:0]         r_food;
    logic                       r_settle;
    logic [TICK_W-1:0]          r_period;

    logic [NUM_LEN-1:0]         w_head;
    logic                       w_hit_body;
    logic                       w_hit_food;
    logic                       w_start_ok;
    logic                       w_wrap;
    logic [TICK_W-1:0]          w_period_next;

    assign w_head     = ctrl_if.body_pos[NUM_LEN-1:0];
    assign w_hit_food = (w_head == r_food);
    assign w_start_ok = ctrl_if.start && (r_state == ST_IDLE || r_state == ST_OVER);

`ifdef SNAKE_SPEEDUP_EN
    assign w_period_next = TICK_W'(calc_period(r_score, 64'(TICK_DIV),
                                               64'(SPEED_STEP), 64'(MIN_DIV)));
`else
    assign w_period_next = TICK_W'(TICK_DIV);
`endif

    // Only segments 1..len-1 belong to the live body.
    always_comb begin
        w_hit_body = 1'b0;
        for (int k = 1; k < MAX_LEN; k++) begin
            if (k < int'(r_len) &&
                ctrl_if.body_pos[k*NUM_LEN +: NUM_LEN] == w_head) begin
                w_hit_body = 1'b1;
            end
        end
    end

    snake_tick_gen #(
        .TICK_W (TICK_W)
    ) u_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (r_state == ST_RUN),
        .i_clr    (w_start_ok),
        .i_period (r_period),
        .o_wrap   (w_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_step      <= 1'b0;
            r_di        <= DIR_RIGHT;
            r_pend      <= DIR_RIGHT;
            r_len       <= c_INIT_LEN;
            r_food_req  <= 1'b0;
            r_score     <= 8'd0;
            r_game_over <= 1'b0;
            r_food      <= '0;
            r_settle    <= 1'b0;
            r_period    <= TICK_W'(TICK_DIV);
        end else begin
            r_step     <= 1'b0;
            r_food_req <= 1'b0;

            // Filter against the committed direction; a later press replaces
            // an earlier one until the next step commits it.
            if (ctrl_if.btn_valid && r_state != ST_OVER &&
                !is_opposite(ctrl_if.btn_dir, r_di)) begin
                r_pend <= ctrl_if.btn_dir;
            end

            case (r_state)
                ST_IDLE, ST_OVER: begin
                    if (ctrl_if.start) begin
                        r_food_req  <= 1'b1;
                        r_len       <= c_INIT_LEN;
                        r_score     <= 8'd0;
                        r_di        <= DIR_RIGHT;
                        r_pend      <= DIR_RIGHT;
                        r_game_over <= 1'b0;
                        r_state     <= ST_FOOD;
                    end
                end
                ST_FOOD: begin
                    if (ctrl_if.food_valid) begin
                        r_food   <= ctrl_if.food_pos;
                        r_period <= w_period_next;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_wrap) begin
                        r_step   <= 1'b1;
                        r_di     <= r_pend;
                        r_settle <= 1'b0;
                        r_state  <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_settle) begin
                        r_settle <= 1'b0;
                        r_state  <= ST_EVAL;
                    end else begin
                        r_settle <= 1'b1;
                    end
                end
                ST_EVAL: begin
                    if (ctrl_if.should_stop || w_hit_body) begin
                        r_game_over <= 1'b1;
                        r_state     <= ST_OVER;
                    end else if (w_hit_food) begin
                        if (r_len != c_LEN_MAX) begin
                            r_len <= r_len + MAX_LEN_BIT_LEN'(1);
                        end
                        if (r_score != 8'hFF) begin
                            r_score <= r_score + 8'd1;
                        end
                        r_food_req <= 1'b1;
                        r_state    <= ST_FOOD;
                    end else begin
                        r_period <= w_period_next;
                        r_state  <= ST_RUN;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ctrl_if.step      = r_step;
    assign ctrl_if.di        = r_di;
    assign ctrl_if.len       = r_len;
    assign ctrl_if.food_req  = r_food_req;
    assign ctrl_if.score     = r_score;
    assign ctrl_if.game_over = r_game_over;
endmodule

`default_nettype wire

// File: tb/tb_snake_game_ctrl.sv
// ============================================================================
// Module : tb_snake_game_ctrl
// Brief  : Directed self-checking bench for snake_game_ctrl.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_snake_game_ctrl;
    import snake_pkg::*;

    localparam int c_MAX_LEN    = 16;
    localparam int c_NUM_LEN    = 10;
    localparam int c_LEN_W      = 4;
    localparam int c_TICK_W     = 5;
`ifdef SNAKE_SPEEDUP_EN
    localparam int c_TICK_DIV   = 20;
`else
    localparam int c_TICK_DIV   = 8;
`endif
    localparam int c_SPEED_STEP = 4;
    localparam int c_MIN_DIV    = 8;
    localparam int c_BOUND      = 100;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    int   n;
    int   s;

    always #5 clk = ~clk;

    snake_game_ctrl_if #(
        .MAX_LEN         (c_MAX_LEN),
        .NUM_LEN         (c_NUM_LEN),
        .MAX_LEN_BIT_LEN (c_LEN_W)
    ) bus ();

    snake_game_ctrl #(
        .MAX_LEN         (c_MAX_LEN),
        .NUM_LEN         (c_NUM_LEN),
        .MAX_LEN_BIT_LEN (c_LEN_W),
        .INIT_LEN        (3),
        .TICK_DIV        (c_TICK_DIV),
        .TICK_W          (c_TICK_W),
        .SPEED_STEP      (c_SPEED_STEP),
        .MIN_DIV         (c_MIN_DIV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ctrl_if (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Hand model of the run-phase length for a given score.
    function automatic int exp_period(input int sc);
`ifdef SNAKE_SPEEDUP_EN
        int p;
        p = 20 - 4 * sc;
        return (p < 8) ? 8 : p;
`else
        return 8 + 0 * sc;
`endif
    endfunction

    task automatic clear_pulses();
        bus.start      = 1'b0;
        bus.btn_valid  = 1'b0;
        bus.food_valid = 1'b0;
    endtask

    task automatic set_body(input logic [9:0] head);
        for (int k = 1; k < c_MAX_LEN; k++) begin
            bus.body_pos[k*c_NUM_LEN +: c_NUM_LEN] = 10'(500 + k);
        end
        bus.body_pos[c_NUM_LEN-1:0] = head;
    endtask

    task automatic wait_step(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            clear_pulses();
            cnt++;
        end while (!bus.step && cnt < c_BOUND);
        if (!bus.step) check("step_seen", 32'(bus.step), 1);
    endtask

    task automatic wait_req(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            clear_pulses();
            cnt++;
        end while (!bus.food_req && cnt < c_BOUND);
        if (!bus.food_req) check("food_req_seen", 32'(bus.food_req), 1);
    endtask

    task automatic count_steps(input int cyc, output int st);
        st = 0;
        for (int i = 0; i < cyc; i++) begin
            @(negedge clk);
            clear_pulses();
            if (bus.step) st++;
        end
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("start_food_req", 32'(bus.food_req), 1);
        check("start_len", 32'(bus.len), 3);
        check("start_score", 32'(bus.score), 0);
        check("start_game_over", 32'(bus.game_over), 0);
        check("start_di", 32'(bus.di), 32'(DIR_RIGHT));
    endtask

    // Feed food, take one plain step, then steer the head onto the food.
    task automatic grow(input logic [9:0] fpos, input int sc);
        int c;
        bus.food_valid = 1'b1;
        bus.food_pos   = fpos;
        wait_step(c);
        check("run_lat", c, exp_period(sc) + 1);
        wait_step(c);
        check("step_period", c, exp_period(sc) + 3);
        set_body(fpos);
        wait_req(c);
        check("eat_lat", c, 3);
        set_body(10'd200);
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.btn_valid   = 1'b0;
        bus.btn_dir     = 2'b00;
        bus.should_stop = 1'b0;
        bus.food_valid  = 1'b0;
        bus.food_pos    = '0;
        bus.body_pos    = '0;
        set_body(10'd200);
        repeat (3) @(negedge clk);

        check("rst_step", 32'(bus.step), 0);
        check("rst_di", 32'(bus.di), 32'(DIR_RIGHT));
        check("rst_len", 32'(bus.len), 3);
        check("rst_food_req", 32'(bus.food_req), 0);
        check("rst_score", 32'(bus.score), 0);
        check("rst_game_over", 32'(bus.game_over), 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_start();
        @(negedge clk);
        check("food_req_pulse", 32'(bus.food_req), 0);
        count_steps(12, s);
        check("food_hold_steps", s, 0);
        bus.food_valid = 1'b1;
        bus.food_pos   = 10'd100;
        wait_step(n);
        check("first_step_lat", n, exp_period(0) + 1);
        check("first_step_di", 32'(bus.di), 32'(DIR_RIGHT));
        check("first_step_len", 32'(bus.len), 3);

        bus.btn_valid = 1'b1;
        bus.btn_dir   = DIR_LEFT;
        wait_step(n);
        check("step_interval", n, exp_period(0) + 3);
        check("di_no_reverse", 32'(bus.di), 32'(DIR_RIGHT));
        bus.btn_valid = 1'b1;
        bus.btn_dir   = DIR_UP;
        @(negedge clk);
        bus.btn_valid = 1'b1;
        bus.btn_dir   = DIR_DOWN;
        wait_step(n);
        check("di_latest_wins", 32'(bus.di), 32'(DIR_DOWN));

        set_body(10'd100);
        wait_req(n);
        check("food_req_lat", n, 3);
        check("eat_len", 32'(bus.len), 4);
        check("eat_score", 32'(bus.score), 1);
        set_body(10'd200);
        count_steps(30, s);
        check("no_step_wait_food", s, 0);
        bus.food_valid = 1'b1;
        bus.food_pos   = 10'd300;
        wait_step(n);
        check("step_after_food", n, exp_period(1) + 1);

        bus.should_stop = 1'b1;
        repeat (2) @(negedge clk);
        check("wall_not_yet", 32'(bus.game_over), 0);
        @(negedge clk);
        check("wall_game_over", 32'(bus.game_over), 1);
        bus.should_stop = 1'b0;
        count_steps(30, s);
        check("over_no_step", s, 0);

        do_start();
        grow(10'd300, 0);
        grow(10'd301, 1);
        check("grow_len", 32'(bus.len), 5);
        check("grow_score", 32'(bus.score), 2);
        bus.food_valid = 1'b1;
        bus.food_pos   = 10'd400;
        wait_step(n);
        set_body(10'd700);
        bus.body_pos[5*c_NUM_LEN +: c_NUM_LEN] = 10'd700;
        wait_step(n);
        check("seg_beyond_len_runs", n, exp_period(2) + 3);
        check("seg_beyond_len_alive", 32'(bus.game_over), 0);
        bus.body_pos[4*c_NUM_LEN +: c_NUM_LEN] = 10'd700;
        repeat (3) @(negedge clk);
        check("seg_len_m1_hit", 32'(bus.game_over), 1);
        set_body(10'd200);

        do_start();
        for (int i = 0; i < 5; i++) begin
            grow(10'(310 + i), i);
        end
        check("speed_score", 32'(bus.score), 5);
        check("speed_len", 32'(bus.len), 8);
        bus.food_valid = 1'b1;
        bus.food_pos   = 10'd450;
        wait_step(n);
        bus.btn_valid = 1'b1;
        bus.btn_dir   = DIR_UP;
        wait_step(n);
        check("score5_period", n, exp_period(5) + 3);
        check("score5_di", 32'(bus.di), 32'(DIR_UP));

        #1 rst_n = 1'b0;
        #1;
        check("settle_rst_step", 32'(bus.step), 0);
        check("settle_rst_di", 32'(bus.di), 32'(DIR_RIGHT));
        check("settle_rst_len", 32'(bus.len), 3);
        check("settle_rst_score", 32'(bus.score), 0);
        check("settle_rst_game_over", 32'(bus.game_over), 0);
        @(negedge clk);
        rst_n = 1'b1;
        count_steps(30, s);
        check("idle_after_rst_steps", s, 0);
        check("idle_after_rst_req", 32'(bus.food_req), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire
